// File: rtl/id_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// id_scroll_ctrl / seven_segment
//
// Scroll controller for the student-ID display. An 8-digit ID is latched and a
// 4-digit window walks through it (followed by four blank positions) on a
// programmable prescaler tick, driving four active-low seven-segment displays.
//
// Ports (id_scroll_ctrl):
//   clk        system clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   id_in      ID digits, [31:28] is the first (leftmost) digit
//   load       capture id_in, rewind to position 0, enter SHOW
//   clear      blank the display and return to IDLE (ID is kept)
//   run        1 lets the prescaler count and the window step
//   dir        0 steps forward, 1 steps backward
//   hex3..hex0 active-low segments, hex3 is the leftmost display
//   pos        current window start index, 0..11
//   active     1 while in SHOW
//
// Ports (seven_segment):
//   digit      4-bit hex value
//   seg        active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------

module seven_segment (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7f;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0e;
      default: seg = 7'h7f;
    endcase
  end

endmodule

module id_scroll_ctrl #(
  parameter int STEP_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_in,
  input  logic        load,
  input  logic        clear,
  input  logic        run,
  input  logic        dir,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic [3:0]  pos,
  output logic        active
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t         state, state_next;
  logic [3:0]     pos_q, pos_next;
  logic [PW-1:0]  presc, presc_next;
  logic [31:0]    id_reg, id_next;
  logic [3:0]     pos_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pos_q  <= 4'd0;
      presc  <= '0;
      id_reg <= 32'd0;
    end else begin
      state  <= state_next;
      pos_q  <= pos_next;
      presc  <= presc_next;
      id_reg <= id_next;
    end
  end

  // Next window position for one step, wrapping inside 0..11 in either direction.
  always_comb begin
    pos_step = 4'd0;
    if (dir) begin
      pos_step = (pos_q == 4'd0) ? 4'd11 : pos_q - 4'd1;
    end else begin
      pos_step = (pos_q == 4'd11) ? 4'd0 : pos_q + 4'd1;
    end
  end

  // clear beats load, and load beats a step: a load on a tick cycle rewinds
  // the window and restarts the prescaler instead of stepping.
  always_comb begin
    state_next = state;
    pos_next   = pos_q;
    presc_next = presc;
    id_next    = id_reg;
    case (state)
      IDLE: begin
        pos_next   = 4'd0;
        presc_next = '0;
        if (!clear && load) begin
          id_next    = id_in;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (clear) begin
          state_next = IDLE;
          pos_next   = 4'd0;
          presc_next = '0;
        end else if (load) begin
          id_next    = id_in;
          pos_next   = 4'd0;
          presc_next = '0;
        end else if (run) begin
          if (presc == LAST) begin
            presc_next = '0;
            pos_next   = pos_step;
          end else begin
            presc_next = presc + PW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        pos_next   = 4'd0;
        presc_next = '0;
      end
    endcase
  end

  assign pos    = pos_q;
  assign active = (state == SHOW);

  logic [6:0] win_seg [4];

  // Each display g shows character (pos+g) mod 12. Indices 8..11 are the
  // blank tail, and everything is blank outside SHOW.
  for (genvar g = 0; g < 4; g++) begin : g_win
    logic [4:0]  sum;
    logic [3:0]  idx;
    logic [31:0] shifted;
    logic [6:0]  dec_seg;

    always_comb begin
      sum = {1'b0, pos_q} + 5'(g);
      if (sum >= 5'd12) begin
        sum = sum - 5'd12;
      end
      idx     = sum[3:0];
      shifted = id_reg << {idx[2:0], 2'b00};
    end

    seven_segment u_dec (
      .digit (shifted[31:28]),
      .seg   (dec_seg)
    );

    assign win_seg[g] = (active && !idx[3]) ? dec_seg : 7'h7f;
  end

  assign hex3 = win_seg[0];
  assign hex2 = win_seg[1];
  assign hex1 = win_seg[2];
  assign hex0 = win_seg[3];

endmodule

// File: tb/tb_id_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_scroll_ctrl
//
// Directed bench for id_scroll_ctrl with STEP_DIV = 4. Stimulus pushes the
// hand-computed expected display state into a queue and strobes the monitor,
// which samples the DUT shortly after the strobe and compares.
// ---------------------------------------------------------------------------

module tb_id_scroll_ctrl;

  localparam int STEP_DIV = 4;

  localparam logic [6:0] BL = 7'h7f;
  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12;
  localparam logic [6:0] S8 = 7'h00;
  localparam logic [6:0] S9 = 7'h10;
  localparam logic [6:0] SA = 7'h08;
  localparam logic [6:0] SB = 7'h03;
  localparam logic [6:0] SC = 7'h46;
  localparam logic [6:0] SD = 7'h21;
  localparam logic [6:0] SE = 7'h06;
  localparam logic [6:0] SF = 7'h0e;

  logic        clk;
  logic        rst_n;
  logic [31:0] id_in;
  logic        load;
  logic        clear;
  logic        run;
  logic        dir;
  logic [6:0]  hex3, hex2, hex1, hex0;
  logic [3:0]  pos;
  logic        active;

  id_scroll_ctrl #(.STEP_DIV(STEP_DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .id_in  (id_in),
    .load   (load),
    .clear  (clear),
    .run    (run),
    .dir    (dir),
    .hex3   (hex3),
    .hex2   (hex2),
    .hex1   (hex1),
    .hex0   (hex0),
    .pos    (pos),
    .active (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] h3;
    logic [6:0] h2;
    logic [6:0] h1;
    logic [6:0] h0;
    logic [3:0] p;
    logic       a;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Monitor: on each strobe, sample slightly later and drain the scoreboard.
  initial begin
    forever begin
      @(sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        tests_run++;
        if ({hex3, hex2, hex1, hex0, pos, active} !== {e.h3, e.h2, e.h1, e.h0, e.p, e.a}) begin
          tests_failed++;
          $display("[TB] FAIL %s: got hex=%h,%h,%h,%h pos=%0d active=%b, expected hex=%h,%h,%h,%h pos=%0d active=%b",
                   e.name, hex3, hex2, hex1, hex0, pos, active, e.h3, e.h2, e.h1, e.h0, e.p, e.a);
        end
      end
    end
  end

  // Drive inputs, then let n rising edges pass; returns on a falling edge.
  task automatic applyStimulus(input logic ld, input logic clr, input logic rn,
                               input logic dr, input logic [31:0] id, input int n);
    load  = ld;
    clear = clr;
    run   = rn;
    dir   = dr;
    id_in = id;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0,
                             input logic [3:0] ep, input logic ea);
    exp_t e;
    e.name = name;
    e.h3 = e3;
    e.h2 = e2;
    e.h1 = e1;
    e.h0 = e0;
    e.p  = ep;
    e.a  = ea;
    exp_q.push_back(e);
    ->sample_ev;
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    id_in = 32'd0;
    load  = 1'b0;
    clear = 1'b0;
    run   = 1'b0;
    dir   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset", BL, BL, BL, BL, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load and forward scroll
    applyStimulus(1, 0, 1, 0, 32'h12345678, 1);
    checkOutput("load_1234", S1, S2, S3, S4, 4'd0, 1'b1);
    applyStimulus(0, 0, 1, 0, 32'h0, 4);
    checkOutput("fwd_pos1", S2, S3, S4, S5, 4'd1, 1'b1);
    applyStimulus(0, 0, 1, 0, 32'h0, 24);
    checkOutput("fwd_pos7", S8, BL, BL, BL, 4'd7, 1'b1);
    applyStimulus(0, 0, 1, 0, 32'h0, 16);
    checkOutput("fwd_pos11", BL, S1, S2, S3, 4'd11, 1'b1);
    applyStimulus(0, 0, 1, 0, 32'h0, 4);
    checkOutput("fwd_wrap0", S1, S2, S3, S4, 4'd0, 1'b1);

    // Backward wrap and freeze
    applyStimulus(0, 0, 1, 1, 32'h0, 4);
    checkOutput("bwd_wrap11", BL, S1, S2, S3, 4'd11, 1'b1);
    applyStimulus(0, 0, 1, 1, 32'h0, 2);
    applyStimulus(0, 0, 0, 1, 32'h0, 10);
    checkOutput("freeze_hold", BL, S1, S2, S3, 4'd11, 1'b1);
    applyStimulus(0, 0, 1, 1, 32'h0, 1);
    checkOutput("resume_partial", BL, S1, S2, S3, 4'd11, 1'b1);
    applyStimulus(0, 0, 1, 1, 32'h0, 1);
    checkOutput("resume_step", BL, BL, S1, S2, 4'd10, 1'b1);

    // Priority
    applyStimulus(1, 1, 1, 0, 32'h12345678, 1);
    checkOutput("clear_over_load", BL, BL, BL, BL, 4'd0, 1'b0);
    applyStimulus(1, 0, 1, 0, 32'h12345678, 1);
    applyStimulus(0, 0, 1, 0, 32'h0, 3);
    applyStimulus(1, 0, 1, 0, 32'h12345678, 1);
    checkOutput("load_on_tick", S1, S2, S3, S4, 4'd0, 1'b1);
    applyStimulus(0, 0, 1, 0, 32'h0, 3);
    checkOutput("prescaler_restart", S1, S2, S3, S4, 4'd0, 1'b1);
    applyStimulus(0, 0, 1, 0, 32'h0, 1);
    checkOutput("step_after_reload", S2, S3, S4, S5, 4'd1, 1'b1);

    // Hex digits
    applyStimulus(1, 0, 1, 0, 32'hABCDEF09, 1);
    checkOutput("load_abcd", SA, SB, SC, SD, 4'd0, 1'b1);
    applyStimulus(0, 0, 1, 0, 32'h0, 16);
    checkOutput("hex_pos4", SE, SF, S0, S9, 4'd4, 1'b1);
    applyStimulus(0, 0, 1, 0, 32'h0, 4);
    checkOutput("hex_pos5", SF, S0, S9, BL, 4'd5, 1'b1);

    // Asynchronous reset mid-scroll
    #1;
    rst_n = 1'b0;
    checkOutput("async_reset", BL, BL, BL, BL, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 32'h0, 5);
    checkOutput("idle_after_reset", BL, BL, BL, BL, 4'd0, 1'b0);
    applyStimulus(1, 0, 1, 0, 32'h12345678, 1);
    checkOutput("load_after_reset", S1, S2, S3, S4, 4'd0, 1'b1);

    #5;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
